// File: rtl/fxp_mul.sv
// Signed QI.F fixed-point multiplier: combinational rounded/saturated product plus a registered copy.
// Optional FXP_MUL_SAT_CNT_EN adds a 16-bit saturation event counter output sat_cnt.
module fxp_mul #(
    parameter int N = 8,
    parameter int F = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic                in_valid,
    input  logic                clr_sticky,
    output logic signed [N-1:0] y,
    output logic                sat,
    output logic signed [N-1:0] y_q,
    output logic                out_valid,
    output logic                sat_sticky
`ifdef FXP_MUL_SAT_CNT_EN
    ,
    output logic [15:0]         sat_cnt
`endif
);

    localparam int W   = 2 * N + 1;
    localparam int RSH = (F > 0) ? F - 1 : 0;
    localparam logic signed [W-1:0] ONE  = W'(1);
    localparam logic signed [W-1:0] RND  = (F > 0) ? (ONE <<< RSH) : '0;
    localparam logic signed [W-1:0] MAXV = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};
    localparam logic [N-1:0]        YMAX = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]        YMIN = {1'b1, {(N - 1){1'b0}}};

    // Extra headroom bit keeps the half-LSB addition from ever wrapping.
    function automatic logic signed [W-1:0] round_fn(input logic signed [W-1:0] p);
        logic signed [W-1:0] s;
        s = p + RND;
        return s >>> F;
    endfunction

    // Returns {sat, y}.
    function automatic logic [N:0] sat_fn(input logic signed [W-1:0] r);
        if (r > MAXV) begin
            return {1'b1, YMAX};
        end else if (r < MINV) begin
            return {1'b1, YMIN};
        end else begin
            return {1'b0, r[N-1:0]};
        end
    endfunction

    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;
    logic signed [2*N-1:0] prod;
    logic signed [W-1:0]   prod_w;
    logic signed [W-1:0]   r;
    logic [N:0]            ys;

    assign a_ext  = {{N{a[N-1]}}, a};
    assign b_ext  = {{N{b[N-1]}}, b};
    assign prod   = a_ext * b_ext;
    assign prod_w = {prod[2*N-1], prod};
    assign r      = round_fn(prod_w);
    assign ys     = sat_fn(r);
    assign sat    = ys[N];
    assign y      = ys[N-1:0];

    logic signed [N-1:0] y_hold_q, y_hold_d;
    logic                out_valid_q, out_valid_d;
    logic                sticky_q, sticky_d;

    always_comb begin
        y_hold_d    = in_valid ? y : y_hold_q;
        out_valid_d = in_valid;
        sticky_d    = (sticky_q | (in_valid & sat)) & ~clr_sticky;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_hold_q    <= '0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            y_hold_q    <= y_hold_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
        end
    end

    assign y_q        = y_hold_q;
    assign out_valid  = out_valid_q;
    assign sat_sticky = sticky_q;

`ifdef FXP_MUL_SAT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter pins at all-ones rather than wrapping; a clear takes priority.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_sticky) begin
            cnt_d = '0;
        end else if (in_valid && sat && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fxp_mul.sv
// Scoreboard bench for fxp_mul (N=8, F=7): random captures checked by a separate monitor,
// directed combinational vectors, asynchronous reset checks and a full a/b sweep of y/sat.
module tb_fxp_mul;

    localparam int N    = 8;
    localparam int F    = 7;
    localparam int YMAX = (1 << (N - 1)) - 1;
    localparam int YMIN = -(1 << (N - 1));

    logic                clk = 1'b0;
    logic                rst_n;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic                in_valid;
    logic                clr_sticky;
    logic signed [N-1:0] y;
    logic                sat;
    logic signed [N-1:0] y_q;
    logic                out_valid;
    logic                sat_sticky;
`ifdef FXP_MUL_SAT_CNT_EN
    logic [15:0]         sat_cnt;
`endif

    fxp_mul #(.N(N), .F(F)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .clr_sticky (clr_sticky),
        .y          (y),
        .sat        (sat),
        .y_q        (y_q),
        .out_valid  (out_valid),
        .sat_sticky (sat_sticky)
`ifdef FXP_MUL_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_ov     = 0;
    int exp_hold   = 0;
    bit exp_sticky = 1'b0;
    int exp_cnt    = 0;
    bit mon_en     = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Reference: exact product, add half an output LSB, floor-divide by 2^F, clamp.
    function automatic void ref_mul(input int av, input int bv, output int yv, output bit sv);
        longint p;
        longint r;
        p = longint'(av) * longint'(bv);
        if (F > 0) r = (p + (longint'(1) << (F - 1))) >>> F;
        else       r = p;
        sv = (r > YMAX) || (r < YMIN);
        if (r > YMAX)      yv = YMAX;
        else if (r < YMIN) yv = YMIN;
        else               yv = int'(r);
    endfunction

    // Entered just after a rising edge; leaves 1 time unit after the next one.
    task automatic cycle(input int av, input int bv, input bit v, input bit clr);
        int yv;
        bit sv;
        a          = av[N-1:0];
        b          = bv[N-1:0];
        in_valid   = v;
        clr_sticky = clr;
        ref_mul(av, bv, yv, sv);
        @(posedge clk);
        if (v) begin
            exp_q.push_back(yv);
            exp_hold = yv;
        end
        exp_ov     = int'(v);
        exp_sticky = clr ? 1'b0 : (exp_sticky | (v & sv));
        if (clr)                              exp_cnt = 0;
        else if (v && sv && exp_cnt < 65535)  exp_cnt++;
        #1;
    endtask

    task automatic comb(input int av, input int bv, input string nm);
        int yv;
        bit sv;
        a = av[N-1:0];
        b = bv[N-1:0];
        #1;
        ref_mul(av, bv, yv, sv);
        chk({nm, "_y"}, int'(y), yv);
        chk({nm, "_sat"}, int'(sat), int'(sv));
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_y_q"}, int'(y_q), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_sat_sticky"}, int'(sat_sticky), 0);
`ifdef FXP_MUL_SAT_CNT_EN
        chk({nm, "_sat_cnt"}, int'(sat_cnt), 0);
`endif
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_ov     = 0;
        exp_hold   = 0;
        exp_sticky = 1'b0;
        exp_cnt    = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("out_valid", int'(out_valid), exp_ov);
            chk("sat_sticky", int'(sat_sticky), int'(exp_sticky));
`ifdef FXP_MUL_SAT_CNT_EN
            chk("sat_cnt", int'(sat_cnt), exp_cnt);
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    chk("y_q", int'(y_q), exp_q.pop_front());
                end
            end else begin
                chk("y_q_hold", int'(y_q), exp_hold);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        a          = '0;
        b          = '0;
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        #3;
        chk_reset_state("reset_initial");

        comb(64, 64, "half_by_half");
        comb(127, 127, "max_by_max");
        comb(-128, -128, "min_by_min");
        comb(-128, 127, "min_by_max");
        comb(50, -50, "neg_round");
        comb(1, -64, "neg_half_tie");
        comb(0, -128, "zero");

        // A capture attempt under reset must leave nothing behind.
        a        = 8'h80;
        b        = 8'h80;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("reset_held_edge");
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        cycle(-128, -128, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b0);
        cycle(-128, -128, 1'b1, 1'b1);
        cycle(64, 64, 1'b1, 1'b0);
        cycle(-128, -128, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int av;
            int bv;
            av = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            bv = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            cycle(av, bv, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset between edges with a capture pending.
        cycle(-128, -128, 1'b1, 1'b0);
        a        = 8'd100;
        b        = 8'd100;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("reset_async");
        clear_model();
        @(posedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, 1'b0, 1'b0);
        cycle(50, -50, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b0);

        // Registered state is static while in_valid=0, so sweep y/sat with the clock running.
        for (int i = -128; i < 128; i++) begin
            for (int j = -128; j < 128; j++) begin
                comb(i, j, "sweep");
            end
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
